imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Owns the single-port synchronous instruction memory and shares it between the fetch stage (reads) and the program loader (writes). After reset it holds the core while the loader fills memory. It then serves fetch reads, including halfword-aligned (RV32C, `addr[1]=1`) fetches that straddle two memory words. Runtime loader writes pre-empt fetch by stalling it.

## Interface
- `MEM_ADDR_W`, default 10: memory word-address width; depth = 2^MEM_ADDR_W 32-bit words.
- `BOOT_EN`, default 1: 1 = leave reset in BOOT; 0 = leave reset in RUN.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `fetch_req`  in  1  fetch wants the 32 bits at `fetch_addr` this cycle.
- `fetch_addr`  in  32  byte address; bit 0 ignored; bit 1 selects misaligned access.
- `fetch_abort`  in  1  redirect/flush; cancels an in-progress split fetch.
- `fetch_stall`  out  1  request not accepted this cycle; fetch holds PC (drives `pc_write` low).
- `fetch_valid`  out  1  `fetch_data` carries a completed read.
- `fetch_data`  out  32  instruction bits; 0 when `fetch_valid`=0.
- `ld_valid`  in  1  loader write request.
- `ld_addr`  in  32  loader byte address; bits [1:0] ignored.
- `ld_data`  in  32  loader write data.
- `ld_ready`  out  1  write accepted this cycle (handshake completes on `ld_valid && ld_ready`).
- `ld_done`  in  1  pulse; boot load complete.
- `core_hold`  out  1  keep the core frozen (high in BOOT).
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  MEM_ADDR_W  word address.
- `mem_wdata`  out  32  write data (`ld_data`).
- `mem_rdata`  in  32  read data, valid the cycle after `mem_en && !mem_we`.
- `err_oob`  out  1  sticky: a fetch address was out of range.

## Operation
- Word index `w = addr[MEM_ADDR_W+1:2]`. Out of range = `fetch_addr[31:MEM_ADDR_W+2] != 0`.
- FSM states: BOOT, RUN, SPLIT. Reset state is BOOT if `BOOT_EN`=1, otherwise RUN.
- BOOT:
  - `core_hold`=1, `fetch_stall`=1, `ld_ready`=1.
  - Each `ld_valid` cycle writes `ld_data` to word `ld_addr`.
  - `ld_done` moves to RUN. A write in the same cycle as `ld_done` is still performed.
  - `fetch_req` is ignored.
- RUN, priority is loader first:
  - `ld_valid`: write, `ld_ready`=1. If `fetch_req` is also high, `fetch_stall`=1.
  - Else `fetch_req` with `addr[1]`=0: read word w, `fetch_stall`=0, stay in RUN.
  - Else `fetch_req` with `addr[1]`=1: read word w, `fetch_stall`=1, go to SPLIT.
  - No request: `mem_en`=0, `fetch_stall`=0.
  - `ld_done` is ignored outside BOOT.
- SPLIT:
  - Capture `mem_rdata[31:16]` into `half_buf`.
  - Read word (w+1) mod depth; wrap-around is legal. A wrap also sets `err_oob`.
  - `fetch_stall`=0, `ld_ready`=0; the loader waits, so fetch cannot be starved mid-split.
  - Go to RUN.
  - `fetch_abort` in SPLIT: no second read, no `fetch_valid`, go to RUN.
  - `fetch_abort` in RUN only suppresses the response pending from the previous cycle.
- Response:
  - `fetch_valid` is registered: set in the cycle after an aligned read or after the SPLIT second read, unless aborted.
  - `fetch_data` = `mem_rdata` (aligned) or `{mem_rdata[15:0], half_buf}` (split).
- Out of range: the read still happens on the truncated index, `err_oob` is set, and `fetch_data` is forced to 0 while `fetch_valid` is still 1. Only reset clears `err_oob`.

## Timing
- Reset values:
  - State BOOT (RUN if `BOOT_EN`=0).
  - `fetch_valid`=0, `fetch_data`=0, `err_oob`=0, `half_buf`=0.
  - `mem_en`=0, `mem_we`=0.
  - `core_hold`=1 and `fetch_stall`=1 (0/0 if `BOOT_EN`=0).
  - `ld_ready`=1 (RUN with no request also gives 1).
- Aligned fetch: accepted in cycle N, data in N+1.
- Split fetch: stall in N, second read in N+1, data in N+2. Throughput is 1 word per 2 cycles.
- Loader write: lands in the same cycle as the handshake; a read of that word in the next cycle returns the new data.
- Reset mid-SPLIT or mid-BOOT: immediate return to the reset state; any partial `half_buf` is discarded.
- `mem_*` outputs, `fetch_stall`, `ld_ready` and `core_hold` are combinational from state and inputs. `fetch_valid` and the response-type flag are registered.

## Test plan
- Boot load: write 0x00000013 to byte addresses 0x0 through 0xC, then pulse `ld_done` → `core_hold` falls the next cycle. A fetch at 0x4 returns 0x00000013 with `fetch_valid` high one cycle later.
- Split fetch: word0=0x11112222, word1=0x33334444, fetch 0x2 → `fetch_stall` high for 1 cycle, then `fetch_data`=0x44441111 at N+2.
- Collision: `ld_valid` and `fetch_req` together in RUN → write performed, fetch stalled one cycle, then the fetch returns the newly written value if the address matches.
- Abort: fetch 0x6 then `fetch_abort` in SPLIT → no `fetch_valid`. A following aligned fetch of 0x8 is served normally.
- Wrap/OOB: MEM_ADDR_W=10, fetch 0xFFE → second read at word 0 and `err_oob`=1. Fetch 0x1000 → `fetch_data`=0, `err_oob` stays 1.
- Reset asserted mid-SPLIT → outputs return to reset values within the same cycle and `half_buf` is cleared.

Source files
------------

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares a single-port synchronous instruction memory between the
//            fetch stage (reads) and the program loader (writes). Holds the
//            core while the boot image is loaded. Serves aligned fetches in
//            one access and halfword-aligned fetches in two accesses.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int MEM_ADDR_W = 10,
  parameter int BOOT_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // fetch stage
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  input  logic                  fetch_abort,
  output logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_data,
  // program loader
  input  logic                  ld_valid,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  ld_ready,
  input  logic                  ld_done,
  // core control
  output logic                  core_hold,
  // memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  // status
  output logic                  err_oob
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_SPLIT = 2'd2
  } state_t;

  localparam state_t c_RESET_STATE = (BOOT_EN != 0) ? S_BOOT : S_RUN;
  localparam logic [MEM_ADDR_W-1:0] c_IDX_ONE = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [MEM_ADDR_W-1:0] r_split_idx;   // word index of the first half of a split
  logic                  r_split_oob;   // that split fetch was out of range
  logic [15:0]           r_half_buf;    // low half of a split instruction
  logic                  r_fetch_valid;
  logic                  r_resp_split;  // pending response is a split assembly
  logic                  r_resp_oob;    // pending response must read as zero
  logic                  r_err_oob;

  logic [MEM_ADDR_W-1:0] w_fetch_idx;
  logic [MEM_ADDR_W-1:0] w_ld_idx;
  logic [MEM_ADDR_W-1:0] w_split_next;
  logic                  w_fetch_oob;
  logic                  w_split_wrap;
  logic                  w_run_fetch;   // fetch accepted by RUN this cycle
  logic                  w_unused;

  assign w_fetch_idx  = fetch_addr[MEM_ADDR_W+1:2];
  assign w_ld_idx     = ld_addr[MEM_ADDR_W+1:2];
  assign w_fetch_oob  = (fetch_addr[31:MEM_ADDR_W+2] != '0);
  assign w_split_next = r_split_idx + c_IDX_ONE;
  assign w_split_wrap = &r_split_idx;
  assign w_run_fetch  = (r_state == S_RUN) && !ld_valid && fetch_req;

  // Address bits that carry no meaning for a word-organised memory.
  assign w_unused = ^{fetch_addr[0], ld_addr[1:0], ld_addr[31:MEM_ADDR_W+2]};

  // Memory port steering and handshake outputs, decoded from state and inputs.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = w_ld_idx;
    fetch_stall = 1'b0;
    ld_ready    = 1'b0;
    core_hold   = 1'b0;
    case (r_state)
      S_BOOT: begin
        core_hold   = 1'b1;
        fetch_stall = 1'b1;
        ld_ready    = 1'b1;
        mem_en      = ld_valid;
        mem_we      = ld_valid;
      end
      S_RUN: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          // Loader wins; a simultaneous fetch simply waits a cycle.
          mem_en      = 1'b1;
          mem_we      = 1'b1;
          fetch_stall = fetch_req;
        end else if (fetch_req) begin
          mem_en      = 1'b1;
          mem_addr    = w_fetch_idx;
          // A halfword-aligned fetch needs a second word, so hold the PC.
          fetch_stall = fetch_addr[1];
        end
      end
      S_SPLIT: begin
        // Loader is blocked here so a split fetch always completes.
        if (!fetch_abort) begin
          mem_en   = 1'b1;
          mem_addr = w_split_next;
        end
      end
      default: begin
        core_hold   = 1'b1;
        fetch_stall = 1'b1;
      end
    endcase
  end

  // Sequencer: boot/run/split state plus all registered response state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= c_RESET_STATE;
      r_split_idx   <= '0;
      r_split_oob   <= 1'b0;
      r_half_buf    <= 16'h0000;
      r_fetch_valid <= 1'b0;
      r_resp_split  <= 1'b0;
      r_resp_oob    <= 1'b0;
      r_err_oob     <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_resp_split  <= 1'b0;
      r_resp_oob    <= 1'b0;
      case (r_state)
        S_BOOT: begin
          // A write coinciding with ld_done is performed by the comb decode.
          if (ld_done) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_run_fetch) begin
            if (fetch_addr[1]) begin
              r_state     <= S_SPLIT;
              r_split_idx <= w_fetch_idx;
              r_split_oob <= w_fetch_oob;
            end else begin
              r_fetch_valid <= 1'b1;
              r_resp_oob    <= w_fetch_oob;
            end
            if (w_fetch_oob) begin
              r_err_oob <= 1'b1;
            end
          end
        end
        S_SPLIT: begin
          r_state <= S_RUN;
          if (!fetch_abort) begin
            r_half_buf    <= mem_rdata[31:16];
            r_fetch_valid <= 1'b1;
            r_resp_split  <= 1'b1;
            r_resp_oob    <= r_split_oob;
            if (w_split_wrap) begin
              r_err_oob <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= c_RESET_STATE;
        end
      endcase
    end
  end

  // Response assembly; a redirect in the response cycle discards the data.
  always_comb begin
    fetch_valid = r_fetch_valid && !fetch_abort;
    fetch_data  = 32'h0000_0000;
    if (fetch_valid && !r_resp_oob) begin
      fetch_data = r_resp_split ? {mem_rdata[15:0], r_half_buf} : mem_rdata;
    end
  end

  assign mem_wdata = ld_data;
  assign err_oob   = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Directed bench for imem_arbiter with a behavioural single-port
//            synchronous memory attached to the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

  localparam int MEM_ADDR_W = 10;

  logic                  clk;
  logic                  reset_n;
  logic                  fetch_req;
  logic [31:0]           fetch_addr;
  logic                  fetch_abort;
  logic                  fetch_stall;
  logic                  fetch_valid;
  logic [31:0]           fetch_data;
  logic                  ld_valid;
  logic [31:0]           ld_addr;
  logic [31:0]           ld_data;
  logic                  ld_ready;
  logic                  ld_done;
  logic                  core_hold;
  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  err_oob;

  logic [31:0] mem_model [0:(1<<MEM_ADDR_W)-1];

  int n_cmp;
  int n_bad;

  imem_arbiter #(
    .MEM_ADDR_W(MEM_ADDR_W),
    .BOOT_EN   (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_abort(fetch_abort),
    .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .core_hold  (core_hold),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err_oob    (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: write in the access cycle, read data next cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < (1 << MEM_ADDR_W); k++) mem_model[k] = 32'h0;
    mem_rdata   = 32'h0;
    fetch_req   = 1'b0;
    fetch_addr  = 32'h0;
    fetch_abort = 1'b0;
    ld_valid    = 1'b0;
    ld_addr     = 32'h0;
    ld_data     = 32'h0;
    ld_done     = 1'b0;
    reset_n     = 1'b1;
    #1 reset_n  = 1'b0;
    #2;
    // ---- reset values ----
    chk("rst_core_hold",   32'(core_hold),   32'h1);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'h1);
    chk("rst_ld_ready",    32'(ld_ready),    32'h1);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    chk("rst_fetch_data",  fetch_data,       32'h0);
    chk("rst_err_oob",     32'(err_oob),     32'h0);
    chk("rst_mem_en",      32'(mem_en),      32'h0);
    chk("rst_mem_we",      32'(mem_we),      32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---- boot load: 0x13 into words 0..3, ld_done with the last write ----
    for (int i = 0; i < 4; i++) begin
      tick();
      ld_valid   = 1'b1;
      ld_addr    = 32'(i * 4);
      ld_data    = 32'h0000_0013;
      ld_done    = (i == 3);
      fetch_req  = (i == 0);
      fetch_addr = 32'h4;
      #1;
      chk("boot_mem_we",   32'(mem_we),   32'h1);
      chk("boot_mem_addr", 32'(mem_addr), 32'(i));
      chk("boot_hold",     32'(core_hold), 32'h1);
      chk("boot_stall",    32'(fetch_stall), 32'h1);
    end
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    fetch_req = 1'b0;
    #1;
    chk("run_core_hold", 32'(core_hold),   32'h0);
    chk("run_idle_stall", 32'(fetch_stall), 32'h0);
    chk("run_idle_mem_en", 32'(mem_en),     32'h0);
    chk("run_idle_ld_ready", 32'(ld_ready), 32'h1);

    // ---- aligned fetch of 0x4 ----
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    #1;
    chk("al_stall",    32'(fetch_stall), 32'h0);
    chk("al_mem_addr", 32'(mem_addr),    32'h1);
    chk("al_mem_we",   32'(mem_we),      32'h0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("al_valid", 32'(fetch_valid), 32'h1);
    chk("al_data",  fetch_data,       32'h0000_0013);

    // ---- runtime loader writes ----
    tick();
    ld_valid = 1'b1;
    ld_addr  = 32'h0;
    ld_data  = 32'h1111_2222;
    #1;
    chk("rw_ready", 32'(ld_ready), 32'h1);
    chk("rw_we",    32'(mem_we),   32'h1);
    chk("rw_valid_clear", 32'(fetch_valid), 32'h0);
    tick();
    ld_addr = 32'h4;
    ld_data = 32'h3333_4444;
    tick();
    ld_addr = 32'hFFC;
    ld_data = 32'hAAAA_5555;
    #1;
    chk("rw_top_addr", 32'(mem_addr), 32'h3FF);
    tick();
    ld_valid = 1'b0;

    // ---- split fetch of 0x2 ----
    fetch_req  = 1'b1;
    fetch_addr = 32'h2;
    #1;
    chk("sp_stall",    32'(fetch_stall), 32'h1);
    chk("sp_addr0",    32'(mem_addr),    32'h0);
    tick();
    #1;
    chk("sp2_stall",   32'(fetch_stall), 32'h0);
    chk("sp2_ready",   32'(ld_ready),    32'h0);
    chk("sp2_addr1",   32'(mem_addr),    32'h1);
    chk("sp2_valid",   32'(fetch_valid), 32'h0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("sp_valid", 32'(fetch_valid), 32'h1);
    chk("sp_data",  fetch_data,       32'h4444_1111);

    // ---- collision: loader and fetch to word 2 together ----
    tick();
    ld_valid   = 1'b1;
    ld_addr    = 32'h8;
    ld_data    = 32'hDEAD_BEEF;
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    #1;
    chk("col_stall", 32'(fetch_stall), 32'h1);
    chk("col_we",    32'(mem_we),      32'h1);
    chk("col_ready", 32'(ld_ready),    32'h1);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("col2_stall", 32'(fetch_stall), 32'h0);
    chk("col2_we",    32'(mem_we),      32'h0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("col_valid", 32'(fetch_valid), 32'h1);
    chk("col_data",  fetch_data,       32'hDEAD_BEEF);

    // ---- abort in SPLIT, then aligned fetch of 0x8 ----
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h6;
    #1;
    chk("ab_stall", 32'(fetch_stall), 32'h1);
    tick();
    fetch_req   = 1'b0;
    fetch_abort = 1'b1;
    #1;
    chk("ab_mem_en", 32'(mem_en), 32'h0);
    tick();
    fetch_abort = 1'b0;
    fetch_req   = 1'b1;
    fetch_addr  = 32'h8;
    #1;
    chk("ab_no_valid", 32'(fetch_valid), 32'h0);
    chk("ab_next_stall", 32'(fetch_stall), 32'h0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("ab_next_valid", 32'(fetch_valid), 32'h1);
    chk("ab_next_data",  fetch_data,       32'hDEAD_BEEF);

    // ---- wrap: fetch 0xFFE reads word 0x3FF then word 0 ----
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'hFFE;
    #1;
    chk("wr_addr0", 32'(mem_addr), 32'h3FF);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("wr_addr1",   32'(mem_addr), 32'h0);
    chk("wr_err_pre", 32'(err_oob),  32'h0);
    tick();
    #1;
    chk("wr_valid", 32'(fetch_valid), 32'h1);
    chk("wr_data",  fetch_data,       32'h2222_AAAA);
    chk("wr_err",   32'(err_oob),     32'h1);

    // ---- out of range: fetch 0x1000 ----
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h1000;
    #1;
    chk("oob_addr",  32'(mem_addr),    32'h0);
    chk("oob_stall", 32'(fetch_stall), 32'h0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("oob_valid", 32'(fetch_valid), 32'h1);
    chk("oob_data",  fetch_data,       32'h0);
    chk("oob_err",   32'(err_oob),     32'h1);

    // ---- reset asserted mid-SPLIT ----
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h2;
    tick();
    fetch_req = 1'b0;
    #1;
    chk("mid_split_ready", 32'(ld_ready), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mr_hold",  32'(core_hold),      32'h1);
    chk("mr_stall", 32'(fetch_stall),    32'h1);
    chk("mr_ready", 32'(ld_ready),       32'h1);
    chk("mr_valid", 32'(fetch_valid),    32'h0);
    chk("mr_data",  fetch_data,          32'h0);
    chk("mr_err",   32'(err_oob),        32'h0);
    chk("mr_mem_en", 32'(mem_en),        32'h0);
    chk("mr_half",  32'(dut.r_half_buf), 32'h0);
    tick();
    reset_n = 1'b1;

    // ---- re-boot without writes, then fetch word 0 ----
    tick();
    ld_done = 1'b1;
    #1;
    chk("rb_hold", 32'(core_hold), 32'h1);
    tick();
    ld_done    = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    #1;
    chk("rb_run_hold", 32'(core_hold),   32'h0);
    chk("rb_stall",    32'(fetch_stall), 32'h0);
    tick();
    fetch_req = 1'b0;
    #1;
    chk("rb_valid", 32'(fetch_valid), 32'h1);
    chk("rb_data",  fetch_data,       32'h1111_2222);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
